// File: rtl/irq_pkg.sv
// irq_pkg: shared sizes and FSM state type for the interrupt request latch.
package irq_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W = 3;
    typedef enum logic {IDLE, PRESENT} irq_state_t;
endpackage

// File: rtl/prio_pick_8.sv
// prio_pick_8: combinational highest-set-bit selector over an 8-bit vector.
module prio_pick_8
    import irq_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic             any,
    output logic [ID_W-1:0]  idx
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (vec[i]) idx = ID_W'(i);
        any = |vec;
    end
endmodule

// File: rtl/irq_req_latch_8.sv
// irq_req_latch_8: rising-edge request latch with highest-index valid/ack presentation.
// Optional eligibility mask port enabled by defining IRQ_MASK_EN.
module irq_req_latch_8
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
`ifdef IRQ_MASK_EN
    input  logic [N_REQ-1:0] mask,
`endif
    input  logic             ack,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_REQ-1:0] pend,
    output logic             overflow
);
    irq_state_t        state, state_nx;
    logic [N_REQ-1:0]  req_q, rise, clr, elig;
    logic [ID_W-1:0]   id_nx, pick_id;
    logic              any;

    assign rise = req & ~req_q;
    assign irq_valid = (state == PRESENT);
    assign clr = (irq_valid && ack) ? {{(N_REQ-1){1'b0}}, 1'b1} << irq_id : '0;
`ifdef IRQ_MASK_EN
    assign elig = pend & mask;
`else
    assign elig = pend;
`endif

    prio_pick_8 u_pick (.vec(elig), .any(any), .idx(pick_id));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            irq_id   <= '0;
            pend     <= '0;
            overflow <= 1'b0;
            req_q    <= '1;
        end else begin
            state    <= state_nx;
            irq_id   <= id_nx;
            pend     <= (pend & ~clr) | rise;
            overflow <= |(rise & pend & ~clr);
            req_q    <= req;
        end
    end

    // Presented ID is latched once in IDLE and held until acked; no preemption.
    always_comb begin
        state_nx = state;
        id_nx    = irq_id;
        if (state == IDLE && any) begin
            state_nx = PRESENT;
            id_nx    = pick_id;
        end else if (state == PRESENT && ack) begin
            state_nx = IDLE;
        end
    end
endmodule

// File: doc/irq_req_latch_8.md
# irq_req_latch_8

Captures rising edges on eight asynchronous-in-origin (pre-synchronised) request lines into a pending register. Selects the highest-numbered pending request and presents it as a 3-bit ID with a valid/ack handshake. Clears the served bit on acknowledge. Sits directly upstream of the 8-to-3 priority encode path: it turns raw level requests into a stable, held, one-at-a-time coded request stream for the consumer.

## Interface
- `N_REQ`, default 8: number of request lines. Fixed at 8 for this revision.
- `ID_W`, default 3: width of `irq_id`, equal to log2(`N_REQ`).
- `clk`: input, 1 bit. Single clock; all logic on the rising edge.
- `rst_n`: input, 1 bit. Reset is synchronous and active-low.
- `req`: input, 8 bits. Request levels, already synchronous to `clk`. A rising edge posts a request.
- `ack`: input, 1 bit. Consumer accepts the presented ID. Meaningful only while `irq_valid`=1.
- `irq_valid`: output, 1 bit. An ID is being presented.
- `irq_id`: output, 3 bits. Index of the presented request. Bit 7 has the highest priority.
- `pend`: output, 8 bits. Raw pending register.
- `overflow`: output, 1 bit. One-cycle pulse when a rising edge hits an already-pending bit.
- `mask`: input, 8 bits. Present only with `IRQ_MASK_EN`; 1 = bit eligible.

## Operation
- Edge detect:
  - `req_q` holds `req` from the previous cycle.
  - `edge = req & ~req_q`.
  - `req_q` resets to 8'hFF, so a line held high through reset needs a fresh rising edge.
- Pending update each cycle: `pend <= (pend & ~clr) | edge`.
  - `clr` is one-hot at `irq_id` when `irq_valid & ack`, else 0.
  - Set wins over clear on the same bit: a new edge on the bit being acknowledged stays pending.
- Overflow: `overflow <= |(edge & pend & ~clr)`.
- FSM, two states:
  - IDLE:
    - `irq_valid`=0.
    - If any eligible pending bit exists, register the highest eligible index into `irq_id` and go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT:
    - `irq_valid`=1, and `irq_id` is held constant.
    - No preemption: a higher-priority arrival waits.
    - On `ack`=1, clear that pending bit and go to IDLE.
- `ack` while in IDLE is ignored. It has no effect on `pend`.
- Eligible set is `pend` (or `pend & mask` with `IRQ_MASK_EN`).
- Reset values: `pend`=0, `irq_valid`=0, `irq_id`=0, `overflow`=0, FSM=IDLE, `req_q`=8'hFF.
- Reset mid-handshake discards all pending requests and the presented ID. No acknowledge is implied.

## Timing
- `req` rising edge sampled at clock edge t:
  - `pend` bit set after t.
  - FSM loads `irq_id` at t+1.
  - `irq_valid`=1 after t+1. Request-to-valid latency is 2 cycles.
- `ack` sampled high with valid at edge u:
  - `pend` bit cleared and `irq_valid`=0 after u.
  - Next ID presented after u+1 at the earliest. There is one mandatory idle cycle between IDs.
- `overflow` is registered and asserts the cycle after the offending edge.
- `pend` visible on the output the cycle after it is set.

## Configuration
- `IRQ_MASK_EN` defined:
  - `mask` port exists.
  - Masked bits still latch into `pend` and raise `overflow`, but are never presented.
  - A bit that is already in PRESENT is unaffected by a later mask change until acked.
- `IRQ_MASK_EN` undefined:
  - No `mask` port.
  - All pending bits are eligible.

## Structure
- Shared package `irq_pkg`: `N_REQ`, `ID_W`, FSM state enum typedef (IDLE, PRESENT).
- One sub-module `prio_pick_8`: combinational highest-set-bit selector.
  - Input: 8 bits.
  - Outputs: `any` and a 3-bit index.
  - Instanced once on the eligible vector.

## Test plan
- Reset release with `req`=8'h00, then pulse `req[2]`: `irq_valid`=1 with `irq_id`=2 exactly 2 cycles after the edge; `pend`=8'h04.
- `req`=8'h81 in one cycle, ack each ID: IDs presented in order 7 then 0, one idle cycle between; `pend` 8'h81 → 8'h01 → 8'h00.
- While presenting ID 3, raise `req[6]`: `irq_id` stays 3 until ack; ID 6 follows.
- New edge on `req[5]` in the same cycle ID 5 is acked: `pend[5]` remains 1; ID 5 presented again. A second edge on `req[5]` while it is still pending: `overflow` pulses 1 cycle.
- Hold `req[1]` high through reset: no request posted after reset. Assert `rst_n`=0 while `irq_valid`=1: all outputs at reset values next cycle.
- With `IRQ_MASK_EN` and `mask`=8'h7F, `req`=8'h90: only ID 4 presented; `pend` keeps bit 7 set.
